// File: rtl/udp_port_demux.sv
// udp_port_demux: strips the 8-byte UDP header and forwards matched payload with a channel index.
// Define UDP_STATS_EN to build the per-channel frame and drop counters; otherwise they read as zero.
module udp_port_demux #(
  parameter int                      NUM_PORTS = 4,
  parameter logic [16*NUM_PORTS-1:0] PORT_LIST = {16'd5004, 16'd5003, 16'd5002, 16'd5001},
  localparam int                     CHAN_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ip_data_in,
  input  logic                      ip_byte_valid,
  input  logic                      ip_eof,
  input  logic                      ip_err,
  output logic [7:0]                udp_data_out,
  output logic                      udp_byte_valid,
  output logic                      udp_eof,
  output logic                      udp_err,
  output logic [CHAN_W-1:0]         udp_chan,
  output logic [15:0]               udp_src_port,
  output logic [15:0]               udp_payload_len,
  output logic [16*NUM_PORTS-1:0]   stat_frames,
  output logic [15:0]               stat_drops
);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t            state_r, state_nx;
  logic [2:0]        cnt_r, cnt_nx;
  logic [15:0]       src_tmp_r, src_tmp_nx;
  logic [15:0]       dst_tmp_r, dst_tmp_nx;
  logic [15:0]       len_tmp_r, len_tmp_nx;
  logic [15:0]       rem_r, rem_nx;
  logic [15:0]       rem_after_s;
  logic [CHAN_W-1:0] chan_r, chan_nx;
  logic [15:0]       src_r, src_nx;
  logic [15:0]       plen_r, plen_nx;
  logic [7:0]        data_r, data_nx;
  logic              valid_r, valid_nx;
  logic              eof_r, eof_nx;
  logic              err_r, err_nx;
  logic              frame_inc_s;
  logic [CHAN_W-1:0] frame_chan_s;
  logic              drop_inc_s;
  logic              lookup_hit_s;
  logic [CHAN_W-1:0] lookup_chan_s;
  logic [15:0]       hdr_plen_s;

  // Destination port lookup; scanning downwards lets the lowest matching index win.
  always_comb begin
    lookup_hit_s  = 1'b0;
    lookup_chan_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      lookup_chan_s = (dst_tmp_r == PORT_LIST[16*i +: 16]) ? CHAN_W'(i) : lookup_chan_s;
      lookup_hit_s  = lookup_hit_s | (dst_tmp_r == PORT_LIST[16*i +: 16]);
    end
  end

  assign hdr_plen_s = len_tmp_r - 16'd8;

  // Next-state and output decode for the header / payload / discard machine.
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    src_tmp_nx   = src_tmp_r;
    dst_tmp_nx   = dst_tmp_r;
    len_tmp_nx   = len_tmp_r;
    rem_nx       = rem_r;
    rem_after_s  = rem_r;
    chan_nx      = chan_r;
    src_nx       = src_r;
    plen_nx      = plen_r;
    data_nx      = data_r;
    valid_nx     = 1'b0;
    eof_nx       = 1'b0;
    err_nx       = 1'b0;
    frame_inc_s  = 1'b0;
    frame_chan_s = chan_r;
    drop_inc_s   = 1'b0;

    case (state_r)
      ST_HDR: begin
        if (ip_err) begin
          err_nx = (cnt_r != 3'd0);
          cnt_nx = 3'd0;
        end else if (ip_byte_valid) begin
          case (cnt_r)
            3'd0:    src_tmp_nx[15:8] = ip_data_in;
            3'd1:    src_tmp_nx[7:0]  = ip_data_in;
            3'd2:    dst_tmp_nx[15:8] = ip_data_in;
            3'd3:    dst_tmp_nx[7:0]  = ip_data_in;
            3'd4:    len_tmp_nx[15:8] = ip_data_in;
            3'd5:    len_tmp_nx[7:0]  = ip_data_in;
            default: begin end
          endcase
          if (cnt_r == 3'd7) begin
            cnt_nx = 3'd0;
            if (len_tmp_r < 16'd8) begin
              err_nx   = 1'b1;
              state_nx = ip_eof ? ST_HDR : ST_DISCARD;
            end else if (lookup_hit_s) begin
              chan_nx = lookup_chan_s;
              src_nx  = src_tmp_r;
              plen_nx = hdr_plen_s;
              rem_nx  = hdr_plen_s;
              // eof on the last header byte closes the datagram immediately
              if (ip_eof) begin
                state_nx = ST_HDR;
                eof_nx   = 1'b1;
                if (hdr_plen_s != 16'd0) begin
                  err_nx = 1'b1;
                end else begin
                  frame_inc_s  = 1'b1;
                  frame_chan_s = lookup_chan_s;
                end
              end else begin
                state_nx = ST_PAYLOAD;
              end
            end else begin
              drop_inc_s = 1'b1;
              state_nx   = ip_eof ? ST_HDR : ST_DISCARD;
            end
          end else if (ip_eof) begin
            err_nx = 1'b1;
            cnt_nx = 3'd0;
          end else begin
            cnt_nx = cnt_r + 3'd1;
          end
        end else if (ip_eof) begin
          err_nx = 1'b1;
          cnt_nx = 3'd0;
        end else begin
          cnt_nx = cnt_r;
        end
      end

      ST_PAYLOAD: begin
        if (ip_err) begin
          eof_nx   = 1'b1;
          err_nx   = 1'b1;
          cnt_nx   = 3'd0;
          state_nx = ST_HDR;
        end else begin
          // bytes beyond the UDP length are IP padding and vanish silently
          if (ip_byte_valid && (rem_r != 16'd0)) begin
            data_nx     = ip_data_in;
            valid_nx    = 1'b1;
            rem_after_s = rem_r - 16'd1;
          end else begin
            rem_after_s = rem_r;
          end
          rem_nx = rem_after_s;
          if (ip_eof) begin
            eof_nx   = 1'b1;
            cnt_nx   = 3'd0;
            state_nx = ST_HDR;
            if (rem_after_s != 16'd0) begin
              err_nx = 1'b1;
            end else begin
              frame_inc_s = 1'b1;
            end
          end else begin
            state_nx = ST_PAYLOAD;
          end
        end
      end

      ST_DISCARD: begin
        if (ip_err || ip_eof) begin
          cnt_nx   = 3'd0;
          state_nx = ST_HDR;
        end else begin
          state_nx = ST_DISCARD;
        end
      end

      default: begin
        cnt_nx   = 3'd0;
        state_nx = ST_HDR;
      end
    endcase
  end

  // State, header capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_HDR;
      cnt_r     <= 3'd0;
      src_tmp_r <= 16'd0;
      dst_tmp_r <= 16'd0;
      len_tmp_r <= 16'd0;
      rem_r     <= 16'd0;
      chan_r    <= '0;
      src_r     <= 16'd0;
      plen_r    <= 16'd0;
      data_r    <= 8'd0;
      valid_r   <= 1'b0;
      eof_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      src_tmp_r <= src_tmp_nx;
      dst_tmp_r <= dst_tmp_nx;
      len_tmp_r <= len_tmp_nx;
      rem_r     <= rem_nx;
      chan_r    <= chan_nx;
      src_r     <= src_nx;
      plen_r    <= plen_nx;
      data_r    <= data_nx;
      valid_r   <= valid_nx;
      eof_r     <= eof_nx;
      err_r     <= err_nx;
    end
  end

  assign udp_data_out    = data_r;
  assign udp_byte_valid  = valid_r;
  assign udp_eof         = eof_r;
  assign udp_err         = err_r;
  assign udp_chan        = chan_r;
  assign udp_src_port    = src_r;
  assign udp_payload_len = plen_r;

`ifdef UDP_STATS_EN
  logic [15:0] frames_r [NUM_PORTS];
  logic [15:0] drops_r;

  // Saturating good-datagram and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        frames_r[i] <= 16'd0;
      end
      drops_r <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (frame_inc_s && (frame_chan_s == CHAN_W'(i)) && (frames_r[i] != 16'hFFFF)) begin
          frames_r[i] <= frames_r[i] + 16'd1;
        end else begin
          frames_r[i] <= frames_r[i];
        end
      end
      if (drop_inc_s && (drops_r != 16'hFFFF)) begin
        drops_r <= drops_r + 16'd1;
      end else begin
        drops_r <= drops_r;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_frames
    assign stat_frames[16*g +: 16] = frames_r[g];
  end
  assign stat_drops = drops_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = ^{frame_inc_s, frame_chan_s, drop_inc_s};
  assign stat_frames    = '0;
  assign stat_drops     = 16'd0;
`endif

endmodule
